d_ff_pipe: RTL and testbench
============================

Name: d_ff_pipe

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds per-stage valid tracking, a global stall enable, synchronous flush, runtime-selectable output delay tap and an occupancy count.
- Used as a configurable delay and alignment line between datapath blocks. Its valid, stall and flush behaviour must be checkable by a scoreboard bench.

Parameters:
- WIDTH, 8: data width in bits, >= 1.
- DEPTH, 4: number of register stages, >= 1.
- RST_VAL, 0: WIDTH-bit value loaded into every data stage on reset, on flush, and into stage 0 when in_valid=0.
- DW, $clog2(DEPTH+1): derived, not overridable. Width of the dly and occ ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  shift enable. 0 = stall: all stages and valids hold.
- clr  input  1  synchronous flush. Takes priority over en.
- in_valid  input  1  qualifies d_in.
- d_in  input  WIDTH  input data.
- dly  input  DW  selected delay in cycles. Legal range 1..DEPTH.
- d_out  output  WIDTH  data at the selected tap.
- out_valid  output  1  valid at the selected tap.
- occ  output  DW  number of stages currently holding valid data.

Behaviour:
- Reset (rst=0, asynchronous, no wait for clk):
  - all data stages = RST_VAL, all valids = 0, occ = 0.
  - d_out = RST_VAL and out_valid = 0 for any legal dly.
  - Release is sampled on the next rising clk edge.
- Storage: data[0..DEPTH-1] (WIDTH bits each) and v[0..DEPTH-1], all registered.
- Priority at each rising edge, when rst=1: clr first, then en, then hold.
- clr=1:
  - all v = 0, all data = RST_VAL, occ = 0, whatever en and in_valid are.
  - The in-flight d_in is discarded.
- clr=0, en=1:
  - v[0] <= in_valid.
  - data[0] <= d_in if in_valid=1, otherwise RST_VAL.
  - For i >= 1: v[i] <= v[i-1] and data[i] <= data[i-1].
  - The value in the last stage is dropped.
- clr=0, en=0: every register holds. in_valid and d_in are ignored, and a sample presented during a stall is lost.
- Tap select (combinational from registers, no added latency):
  - Effective tap k = 1 if dly=0; k = DEPTH if dly > DEPTH; otherwise k = dly.
  - d_out = data[k-1] and out_valid = v[k-1].
  - A change in dly takes effect in the same cycle.
- Latency: a sample accepted at edge N, with en=1 on every edge, appears at tap k after edge N+k-1.
  - Stalled edges do not advance it; each stalled edge adds one cycle.
- occ: registered population count of v. It equals the count of set v bits after each edge and is independent of dly.
- DEPTH=1: a single stage. dly values 0 and 1 both select it.
- Simultaneous clr and en: clr wins (flush).
- Reset asserted mid-stream: state clears immediately. The first valid output after release needs k enabled edges.

Test Plan:
- WIDTH=8, DEPTH=4, dly=4, en=1, in_valid=1, d_in=0x11,0x22,0x33,0x44,0x55 on successive edges -> d_out shows 0x11 after the 4th edge and 0x55 after the 8th; out_valid=1 from the 4th edge onward; occ=1,2,3,4,4.
- Full pipe of 0xA1..0xA4, sweep dly 0,1,2,3,4,7 in the same cycle with en=0 -> d_out = 0xA4,0xA4,0xA3,0xA2,0xA1,0xA1 combinationally; occ=4 throughout.
- Streaming with en low for 2 cycles mid-stream -> outputs hold; latency of the in-flight samples grows by exactly 2 cycles; no sample is duplicated; samples offered during the stall do not appear.
- in_valid pattern 1,0,1,1 with d_in 0x10,0xFF,0x30,0x40 -> the 0xFF slot reads RST_VAL=0x00 with out_valid=0; occ peaks at 3.
- Full pipe, then clr=1 and en=1 with in_valid=1 and d_in=0x99 -> next edge gives occ=0, out_valid=0, d_out=0x00; 0x99 never emerges.
- rst=0 asserted between clock edges on a full pipe -> occ=0, out_valid=0, d_out=0x00 before the next edge; after release, normal fill resumes.

Source files
------------

// File: rtl/d_ff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid, stall, flush,
// runtime-selectable output tap and a registered occupancy count.

module d_ff_pipe_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] d_o,
    output logic             v_o,
    output logic             v_nxt_o
);

    logic [WIDTH-1:0] d_q, d_d;
    logic             v_q, v_d;

    always_comb begin
        d_d = d_q;
        v_d = v_q;
        if (clr_i) begin
            d_d = RST_VAL;
            v_d = 1'b0;
        end else if (en_i) begin
            d_d = d_i;
            v_d = v_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q <= RST_VAL;
            v_q <= 1'b0;
        end else begin
            d_q <= d_d;
            v_q <= v_d;
        end
    end

    assign d_o     = d_q;
    assign v_o     = v_q;
    assign v_nxt_o = v_d;

endmodule

module d_ff_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              DW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d_in,
    input  logic [DW-1:0]    dly,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic [DW-1:0]    occ
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0]            v_q;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0]            v_d;
    logic [DW-1:0]               occ_q, occ_d;
    logic [IW-1:0]               tap;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        // Stage 0 takes a bubble (RST_VAL, invalid) when the input is not qualified.
        if (g == 0) begin : g_head
            assign src_d[g] = in_valid ? d_in : RST_VAL;
            assign src_v[g] = in_valid;
        end else begin : g_body
            assign src_d[g] = data_q[g-1];
            assign src_v[g] = v_q[g-1];
        end

        d_ff_pipe_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk_i   (clk),
            .rst_ni  (rst),
            .clr_i   (clr),
            .en_i    (en),
            .d_i     (src_d[g]),
            .v_i     (src_v[g]),
            .d_o     (data_q[g]),
            .v_o     (v_q[g]),
            .v_nxt_o (v_d[g])
        );
    end

    function automatic logic [DW-1:0] popcnt(input logic [DEPTH-1:0] v);
        logic [DW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) cnt = cnt + DW'(v[i]);
        return cnt;
    endfunction

    // occ tracks the next valid vector so it lines up with the stages after each edge.
    assign occ_d = popcnt(v_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ_q <= '0;
        else      occ_q <= occ_d;
    end

    always_comb begin
        tap = '0;
        if (dly == '0)              tap = '0;
        else if (dly > DW'(DEPTH))  tap = IW'(DEPTH - 1);
        else                        tap = IW'(dly - 1'b1);
    end

    assign d_out     = data_q[tap];
    assign out_valid = v_q[tap];
    assign occ       = occ_q;

endmodule

// File: tb/tb_d_ff_pipe.sv
// Scoreboard bench for d_ff_pipe: a history-queue reference model plus directed scenarios.

module tb_d_ff_pipe;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, en, clr, in_valid;
    logic [7:0] d_in;
    logic [2:0] dly;
    logic [7:0] d_out;
    logic       out_valid;
    logic [2:0] occ;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    // Newest accepted slot first; each slot is {valid, data}.
    logic [8:0] hist[$];

    d_ff_pipe #(.WIDTH(8), .DEPTH(D), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .in_valid(in_valid),
        .d_in(d_in), .dly(dly), .d_out(d_out), .out_valid(out_valid), .occ(occ)
    );

    always #10 clk = ~clk;

    function automatic void m_edge(input logic e, input logic c, input logic iv, input logic [7:0] d);
        if (c) hist.delete();
        else if (e) begin
            hist.push_front({iv, iv ? d : 8'h00});
            if (hist.size() > D) void'(hist.pop_back());
        end
    endfunction

    function automatic logic [8:0] m_tap(input int dl);
        int k;
        k = (dl == 0) ? 1 : ((dl > D) ? D : dl);
        if (k - 1 < hist.size()) return hist[k-1];
        return 9'h000;
    endfunction

    function automatic int m_occ();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i][8]);
        return n;
    endfunction

    task automatic step(input logic e, input logic c, input logic iv, input logic [7:0] d);
        en = e; clr = c; in_valid = iv; d_in = d;
        @(posedge clk);
        if (rst) m_edge(e, c, iv, d);
        ecnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 0; clr = 0; in_valid = 0; d_in = 8'h00; dly = 3'd1;
        #3;
        for (int i = 0; i < 8; i++) begin
            dly = 3'(i);
            #1;
            total++;
            if ({occ, out_valid, d_out} !== {3'd0, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL reset dly=%0d: occ=%0d ov=%b d=%h want 0/0/00", i, occ, out_valid, d_out);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int occ_exp[5] = '{1, 2, 3, 4, 4};
        logic [8:0] e;
        step(0, 1, 0, 8'h00);
        dly = 3'd4;
        for (int n = 1; n <= 8; n++) begin
            if (n <= 5) step(1, 0, 1, vals[n-1]);
            else        step(1, 0, 0, 8'h00);
            e = m_tap(dly);
            total++;
            if ({out_valid, d_out} !== e || int'(occ) != m_occ()) begin
                bad++;
                $display("FAIL fill edge %0d: ov=%b d=%h occ=%0d want %b/%h/%0d", n, out_valid, d_out, occ, e[8], e[7:0], m_occ());
            end
            if (n <= 5) begin
                total++;
                if (int'(occ) != occ_exp[n-1]) begin
                    bad++;
                    $display("FAIL fill occ edge %0d: got %0d want %0d", n, occ, occ_exp[n-1]);
                end
            end
            if (n >= 4) begin
                total++;
                if (out_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL fill ov edge %0d: got %b want 1", n, out_valid);
                end
            end
        end
        total++;
        if (d_out !== 8'h55) begin
            bad++;
            $display("FAIL fill last: got %h want 55", d_out);
        end
    endtask

    task automatic test_tap_sweep();
        logic [2:0] dls[6]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        logic [7:0] want[6] = '{8'hA4, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA1};
        step(0, 1, 0, 8'h00);
        for (int i = 1; i <= 4; i++) step(1, 0, 1, 8'(8'hA0 + i));
        en = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 6; i++) begin
                dly = dls[i];
                #1;
                total++;
                if ({out_valid, d_out, occ} !== {1'b1, want[i], 3'd4}) begin
                    bad++;
                    $display("FAIL tap dly=%0d: ov=%b d=%h occ=%0d want 1/%h/4", dls[i], out_valid, d_out, occ, want[i]);
                end
            end
            step(0, 0, 1, 8'h5A);
        end
    endtask

    task automatic test_stall();
        logic [7:0] seen[$];
        logic [8:0] e;
        int acc = -1, first = -1;
        step(0, 1, 0, 8'h00);
        dly = 3'd3;
        for (int s = 1; s <= 13; s++) begin
            if (s <= 10) step(1, 0, 1, 8'(8'h60 + s));
            else         step(1, 0, 0, 8'h00);
            if (s == 4) acc = ecnt;
            for (int k = 0; k < 3; k++) begin
                e = m_tap(dly);
                total++;
                if ({out_valid, d_out} !== e || int'(occ) != m_occ() || (out_valid && d_out == 8'hEE)) begin
                    bad++;
                    $display("FAIL stall edge %0d: ov=%b d=%h occ=%0d want %b/%h/%0d", ecnt, out_valid, d_out, occ, e[8], e[7:0], m_occ());
                end
                if (out_valid && (seen.size() == 0 || seen[$] != d_out)) seen.push_back(d_out);
                if (out_valid && d_out == 8'h64 && first < 0) first = ecnt;
                if (s != 4 || k == 2) break;
                step(0, 0, 1, 8'hEE);
            end
        end
        total++;
        if (first - acc != 4) begin
            bad++;
            $display("FAIL stall latency: got %0d want 4", first - acc);
        end
        total++;
        if (seen.size() != 10) begin
            bad++;
            $display("FAIL stall distinct: got %0d want 10", seen.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                total++;
                if (seen[i] !== 8'(8'h61 + i)) begin
                    bad++;
                    $display("FAIL stall order %0d: got %h want %h", i, seen[i], 8'(8'h61 + i));
                end
            end
        end
    endtask

    task automatic test_bubbles();
        logic       ivs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ds[4]   = '{8'h10, 8'hFF, 8'h30, 8'h40};
        int         occs[4] = '{1, 1, 2, 3};
        int         peak = 0;
        step(0, 1, 0, 8'h00);
        dly = 3'd4;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, ivs[i], ds[i]);
            if (int'(occ) > peak) peak = int'(occ);
            total++;
            if (int'(occ) != occs[i]) begin
                bad++;
                $display("FAIL bubble occ edge %0d: got %0d want %0d", i + 1, occ, occs[i]);
            end
        end
        total++;
        if ({out_valid, d_out} !== {1'b1, 8'h10}) begin
            bad++;
            $display("FAIL bubble head: ov=%b d=%h want 1/10", out_valid, d_out);
        end
        dly = 3'd3;
        #1;
        total++;
        if ({out_valid, d_out} !== {1'b0, 8'h00}) begin
            bad++;
            $display("FAIL bubble slot tap3: ov=%b d=%h want 0/00", out_valid, d_out);
        end
        dly = 3'd4;
        step(1, 0, 0, 8'h00);
        if (int'(occ) > peak) peak = int'(occ);
        total++;
        if ({out_valid, d_out} !== {1'b0, 8'h00} || peak != 3) begin
            bad++;
            $display("FAIL bubble slot tap4: ov=%b d=%h peak=%0d want 0/00/3", out_valid, d_out, peak);
        end
    endtask

    task automatic test_flush();
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 8'($urandom_range(1, 200)));
        dly = 3'd1;
        step(1, 1, 1, 8'h99);
        total++;
        if ({occ, out_valid, d_out} !== {3'd0, 1'b0, 8'h00}) begin
            bad++;
            $display("FAIL flush: occ=%0d ov=%b d=%h want 0/0/00", occ, out_valid, d_out);
        end
        for (int n = 0; n < 6; n++) begin
            step(1, 0, 0, 8'h00);
            for (int k = 1; k <= 4; k++) begin
                dly = 3'(k);
                #1;
                total++;
                if (out_valid !== 1'b0 || d_out !== 8'h00) begin
                    bad++;
                    $display("FAIL flush drain n=%0d dly=%0d: ov=%b d=%h want 0/00", n, k, out_valid, d_out);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] e;
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 8'(8'hC0 + i));
        #2;
        rst = 1'b0;
        hist.delete();
        for (int k = 1; k <= 4; k++) begin
            dly = 3'(k);
            #1;
            total++;
            if ({occ, out_valid, d_out} !== {3'd0, 1'b0, 8'h00}) begin
                bad++;
                $display("FAIL async reset dly=%0d: occ=%0d ov=%b d=%h want 0/0/00", k, occ, out_valid, d_out);
            end
        end
        step(1, 0, 1, 8'h77);
        step(1, 0, 1, 8'h78);
        total++;
        if ({occ, out_valid} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset held: occ=%0d ov=%b want 0/0", occ, out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        dly = 3'd2;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 1, 8'(8'hD0 + i));
            e = m_tap(dly);
            total++;
            if ({out_valid, d_out} !== e || int'(occ) != m_occ() || out_valid !== (i >= 1)) begin
                bad++;
                $display("FAIL refill %0d: ov=%b d=%h occ=%0d want %b/%h/%0d", i, out_valid, d_out, occ, e[8], e[7:0], m_occ());
            end
        end
    endtask

    task automatic test_random();
        logic [8:0] e;
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 1'($urandom), 8'($urandom));
            for (int r = 0; r < 2; r++) begin
                dly = 3'($urandom_range(0, 7));
                #1;
                e = m_tap(dly);
                total++;
                if ({out_valid, d_out} !== e || int'(occ) != m_occ()) begin
                    bad++;
                    $display("FAIL random %0d dly=%0d: ov=%b d=%h occ=%0d want %b/%h/%0d", n, dly, out_valid, d_out, occ, e[8], e[7:0], m_occ());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_tap_sweep();
        test_stall();
        test_bubbles();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
